// File: rtl/pcie_tx_rdreq_engine_if.sv
// AXI-Stream TX bus toward the PCIe endpoint core (128-bit Xilinx style).
// master = TLP source (engine), slave = core.
interface pcie_tx_rdreq_engine_if #(
   parameter int P_DATA_WIDTH = 128,
   parameter int P_KEEP_WIDTH = P_DATA_WIDTH/8
);
   logic                    s_axis_tx_tready;
   logic [P_DATA_WIDTH-1:0] s_axis_tx_tdata;
   logic [P_KEEP_WIDTH-1:0] s_axis_tx_tkeep;
   logic                    s_axis_tx_tlast;
   logic                    s_axis_tx_tvalid;

   modport master (
      input  s_axis_tx_tready,
      output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid
   );
   modport slave (
      output s_axis_tx_tready,
      input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid
   );
endinterface

// File: rtl/pcie_tx_rdreq_engine.sv
// Multi-channel DMA read-request engine: round-robin client grant, MRRS splitting
// into single-beat MRd TLPs (3DW/4DW header), tag allocation from a free bitmap.
module pcie_tx_rdreq_engine #(
   parameter int P_DATA_WIDTH = 128,
   parameter int P_KEEP_WIDTH = P_DATA_WIDTH/8,
   parameter int P_CHANNELS   = 4,
   parameter int P_TAG_BITS   = 5,
   parameter int P_MAX_RD_DW  = 128
)(
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   pcie_tx_rdreq_engine_if.master    tx,
   input  logic [15:0]               completer_id,
   input  logic [P_CHANNELS-1:0]     ch_req_valid,
   input  logic [64*P_CHANNELS-1:0]  ch_req_addr,
   input  logic [10*P_CHANNELS-1:0]  ch_req_len,
   output logic [P_CHANNELS-1:0]     ch_req_ready,
   output logic [P_CHANNELS-1:0]     ch_done,
   output logic                      issue_valid,
   output logic [P_TAG_BITS-1:0]     issue_tag,
   output logic [3:0]                issue_ch,
   output logic [10:0]               issue_len,
   input  logic                      tag_free_valid,
   input  logic [P_TAG_BITS-1:0]     tag_free_tag,
   output logic [P_TAG_BITS:0]       tags_outstanding
);
   localparam int NTAGS = 1 << P_TAG_BITS;
   localparam int CH_W  = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;
   localparam int OFF_W = $clog2(P_MAX_RD_DW);

   typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_SEND} state_t;
   typedef struct packed {
      logic [63:0]     addr;
      logic [10:0]     rem;
      logic [CH_W-1:0] ch;
   } req_t;

   state_t state_q, state_n;
   req_t   req_q;

   logic [CH_W-1:0]         last_grant_q, grant_idx;
   logic                    grant_any, req_hs, tx_hs;
   int                      rr_idx;
   logic [9:0]              len_raw;
   logic [NTAGS-1:0]        busy_q, busy_n;
   logic [P_TAG_BITS-1:0]   free_tag, tag_q;
   logic                    tag_avail;
   logic [10:0]             space, chunk_n, chunk_q;
   logic                    is4;
   logic [7:0]              tag8;
   logic [31:0]             dw0, dw1, dw2, dw3;
   logic [P_DATA_WIDTH-1:0] hdr_n, tdata_q;
   logic [P_KEEP_WIDTH-1:0] keep_n, tkeep_q;
   logic                    tlast_q, tvalid_q;

   assign tx.s_axis_tx_tdata  = tdata_q;
   assign tx.s_axis_tx_tkeep  = tkeep_q;
   assign tx.s_axis_tx_tlast  = tlast_q;
   assign tx.s_axis_tx_tvalid = tvalid_q;
   assign tx_hs  = tvalid_q & tx.s_axis_tx_tready;
   assign req_hs = |ch_req_ready;

   // Round-robin: scan downward so the channel nearest after last_grant wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = last_grant_q;
      rr_idx    = 0;
      for (int i = P_CHANNELS; i >= 1; i--) begin
         rr_idx = (int'(last_grant_q) + i) % P_CHANNELS;
         if (ch_req_valid[CH_W'(rr_idx)]) begin
            grant_any = 1'b1;
            grant_idx = CH_W'(rr_idx);
         end
      end
   end

   assign len_raw = ch_req_len[10*grant_idx +: 10];

   always_comb begin
      free_tag  = '0;
      tag_avail = ~&busy_q;
      for (int t = NTAGS-1; t >= 0; t--)
         if (!busy_q[t]) free_tag = P_TAG_BITS'(t);
   end

   always_comb begin
      tags_outstanding = '0;
      for (int t = 0; t < NTAGS; t++)
         tags_outstanding = tags_outstanding + (P_TAG_BITS+1)'(busy_q[t]);
   end

   // Release first, then allocate: a stale release can never clear a fresh allocation.
   always_comb begin
      busy_n = busy_q;
      if (tag_free_valid) busy_n[tag_free_tag] = 1'b0;
      if (tx_hs)          busy_n[tag_q]        = 1'b1;
   end

   // Chunk stops at the next MRRS-aligned address, so it never crosses 4 KB.
   assign space   = 11'(P_MAX_RD_DW) - 11'(req_q.addr[OFF_W+1:2]);
   assign chunk_n = (req_q.rem < space) ? req_q.rem : space;

   always_comb begin
      is4  = |req_q.addr[63:32];
      tag8 = '0;
      tag8[P_TAG_BITS-1:0] = free_tag;
      dw0  = '0;
      dw0[9:0]   = chunk_n[9:0];
      dw0[30:24] = is4 ? 7'b01_00000 : 7'b00_00000;
      dw1  = {completer_id, tag8, (chunk_n == 11'd1) ? 4'h0 : 4'hF, 4'hF};
      dw2  = is4 ? req_q.addr[63:32] : {req_q.addr[31:2], 2'b00};
      dw3  = is4 ? {req_q.addr[31:2], 2'b00} : 32'h0;
      hdr_n  = P_DATA_WIDTH'({dw3, dw2, dw1, dw0});
      keep_n = is4 ? P_KEEP_WIDTH'(16'hFFFF) : P_KEEP_WIDTH'(16'h0FFF);
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_n;

   always_comb begin
      state_n = state_q;
      case (state_q)
         S_IDLE:  if (req_hs)    state_n = S_SPLIT;
         S_SPLIT: if (tag_avail) state_n = S_SEND;
         S_SEND:  if (tx_hs)     state_n = (req_q.rem == chunk_q) ? S_IDLE : S_SPLIT;
         default:                state_n = S_IDLE;
      endcase
   end

   always_comb begin
      ch_req_ready = '0;
      if (i_rst_n && state_q == S_IDLE && grant_any)
         ch_req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_q        <= '0;
         last_grant_q <= CH_W'(P_CHANNELS-1);
         busy_q       <= '0;
         chunk_q      <= '0;
         tag_q        <= '0;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tlast_q      <= 1'b0;
         tvalid_q     <= 1'b0;
         ch_done      <= '0;
         issue_valid  <= 1'b0;
         issue_tag    <= '0;
         issue_ch     <= '0;
         issue_len    <= '0;
      end else begin
         issue_valid <= 1'b0;
         ch_done     <= '0;
         busy_q      <= busy_n;
         case (state_q)
            S_IDLE: if (req_hs) begin
               req_q.addr   <= ch_req_addr[64*grant_idx +: 64];
               req_q.rem    <= (len_raw == 10'd0) ? 11'd1024 : {1'b0, len_raw};
               req_q.ch     <= grant_idx;
               last_grant_q <= grant_idx;
            end
            S_SPLIT: if (tag_avail) begin
               tdata_q  <= hdr_n;
               tkeep_q  <= keep_n;
               tlast_q  <= 1'b1;
               tvalid_q <= 1'b1;
               chunk_q  <= chunk_n;
               tag_q    <= free_tag;
            end
            S_SEND: if (tx_hs) begin
               issue_valid <= 1'b1;
               issue_tag   <= tag_q;
               issue_ch    <= 4'(req_q.ch);
               issue_len   <= chunk_q;
               req_q.addr  <= req_q.addr + {51'b0, chunk_q, 2'b00};
               req_q.rem   <= req_q.rem - chunk_q;
               tvalid_q    <= 1'b0;
               if (req_q.rem == chunk_q) ch_done <= P_CHANNELS'(1) << req_q.ch;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pcie_tx_rdreq_engine.sv
// Directed bench for pcie_tx_rdreq_engine: expected TLPs/issues are queued when a
// request is driven and compared as the DUT emits them.
module tb_pcie_tx_rdreq_engine;
   localparam int CH = 4, TB = 2, MRD = 128;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic              i_rst_n;
   logic [15:0]       completer_id = 16'hBEEF;
   logic [CH-1:0]     ch_req_valid, ch_req_ready, ch_done;
   logic [64*CH-1:0]  ch_req_addr;
   logic [10*CH-1:0]  ch_req_len;
   logic              issue_valid;
   logic [TB-1:0]     issue_tag;
   logic [3:0]        issue_ch;
   logic [10:0]       issue_len;
   logic              tag_free_valid;
   logic [TB-1:0]     tag_free_tag;
   logic [TB:0]       tags_outstanding;

   pcie_tx_rdreq_engine_if #(.P_DATA_WIDTH(128)) tx_if ();

   pcie_tx_rdreq_engine #(.P_DATA_WIDTH(128), .P_CHANNELS(CH), .P_TAG_BITS(TB), .P_MAX_RD_DW(MRD)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .tx(tx_if), .completer_id(completer_id),
      .ch_req_valid(ch_req_valid), .ch_req_addr(ch_req_addr), .ch_req_len(ch_req_len),
      .ch_req_ready(ch_req_ready), .ch_done(ch_done), .issue_valid(issue_valid),
      .issue_tag(issue_tag), .issue_ch(issue_ch), .issue_len(issue_len),
      .tag_free_valid(tag_free_valid), .tag_free_tag(tag_free_tag),
      .tags_outstanding(tags_outstanding));

   typedef struct { logic [127:0] data; logic [15:0] keep; } tlp_t;
   typedef struct { logic [TB-1:0] tag; logic [3:0] ch; logic [10:0] len; logic done; } iss_t;
   tlp_t tlp_q[$];
   iss_t iss_q[$];

   int checks = 0, errors = 0, grant_cnt = 0;
   logic auto_rel = 1'b0;
   logic [CH-1:0] rdy_seen;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] exp_hdr(input logic [63:0] a, input logic [10:0] len, input logic [TB-1:0] tag);
      logic is4;
      logic [31:0] dw0, dw1, dw2, dw3;
      is4 = (a[63:32] != 32'h0);
      dw0 = {1'b0, (is4 ? 7'b0100000 : 7'b0000000), 14'h0, len[9:0]};
      dw1 = {completer_id, 8'(tag), (len == 11'd1) ? 4'h0 : 4'hF, 4'hF};
      dw2 = is4 ? a[63:32] : {a[31:2], 2'b00};
      dw3 = is4 ? {a[31:2], 2'b00} : 32'h0;
      return {dw3, dw2, dw1, dw0};
   endfunction

   task automatic push(input logic [63:0] a, input logic [10:0] len, input int tag, input int ch, input logic done);
      tlp_t t;
      iss_t s;
      t.data = exp_hdr(a, len, TB'(tag));
      t.keep = (a[63:32] != 32'h0) ? 16'hFFFF : 16'h0FFF;
      s.tag = TB'(tag); s.ch = 4'(ch); s.len = len; s.done = done;
      tlp_q.push_back(t);
      iss_q.push_back(s);
   endtask

   // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
   task automatic tick();
      tlp_t t;
      iss_t s;
      logic fired;
      fired = 1'b0;
      @(negedge i_clk);
      rdy_seen = ch_req_ready;
      if (|ch_req_ready) grant_cnt++;
      if (tx_if.s_axis_tx_tvalid && tx_if.s_axis_tx_tready) begin
         if (tlp_q.size() == 0) chk("tlp_unexpected", 1, 0);
         else begin
            t = tlp_q.pop_front();
            chk("tlp_data", tx_if.s_axis_tx_tdata, t.data);
            chk("tlp_keep", tx_if.s_axis_tx_tkeep, t.keep);
            chk("tlp_last", tx_if.s_axis_tx_tlast, 1);
         end
      end
      if (issue_valid) begin
         if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
         else begin
            s = iss_q.pop_front();
            chk("issue_tag", issue_tag, s.tag);
            chk("issue_ch", issue_ch, s.ch);
            chk("issue_len", issue_len, s.len);
            chk("ch_done", ch_done, s.done ? (128'(1) << s.ch) : 128'(0));
         end
         if (auto_rel) begin
            tag_free_valid = 1'b1;
            tag_free_tag   = issue_tag;
            fired          = 1'b1;
         end
      end else if (ch_done != '0) chk("done_spurious", ch_done, 0);
      @(posedge i_clk);
      #1;
      if (fired) tag_free_valid = 1'b0;
   endtask

   task automatic req(input int ch, input logic [63:0] a, input logic [9:0] len);
      ch_req_valid[ch] = 1'b1;
      ch_req_addr[64*ch +: 64] = a;
      ch_req_len[10*ch +: 10]  = len;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (rdy_seen[ch]) begin
            ch_req_valid[ch] = 1'b0;
            return;
         end
      end
      chk("req_timeout", 1, 0);
      ch_req_valid[ch] = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (tlp_q.size() == 0 && iss_q.size() == 0) return;
         tick();
      end
      chk("drain_timeout", tlp_q.size() + iss_q.size(), 0);
   endtask

   task automatic release_tag(input int tag);
      tag_free_valid = 1'b1;
      tag_free_tag   = TB'(tag);
      tick();
      tag_free_valid = 1'b0;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      tick();
      tick();
      i_rst_n = 1'b1;
   endtask

   initial begin
      i_rst_n = 1'b1;
      ch_req_valid = '0; ch_req_addr = '0; ch_req_len = '0;
      tag_free_valid = 1'b0; tag_free_tag = '0;
      tx_if.s_axis_tx_tready = 1'b1;
      ch_req_valid = 4'b0001;
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_tvalid", tx_if.s_axis_tx_tvalid, 0);
      chk("rst_tdata", tx_if.s_axis_tx_tdata, 0);
      chk("rst_tkeep", tx_if.s_axis_tx_tkeep, 0);
      chk("rst_tlast", tx_if.s_axis_tx_tlast, 0);
      chk("rst_ready", ch_req_ready, 0);
      chk("rst_outstanding", tags_outstanding, 0);
      chk("rst_issue", issue_valid, 0);
      chk("rst_done", ch_done, 0);
      ch_req_valid = '0;
      tick(); tick();
      i_rst_n = 1'b1;

      // single 3DW read
      push(64'h1000, 11'd1, 0, 0, 1'b1);
      req(0, 64'h1000, 10'd1);
      chk("lat_e0_tvalid", tx_if.s_axis_tx_tvalid, 0);
      tick();
      chk("lat_e1_tvalid", tx_if.s_axis_tx_tvalid, 1);
      chk("t1_dw0", tx_if.s_axis_tx_tdata[31:0], 32'h00000001);
      chk("t1_dw2", tx_if.s_axis_tx_tdata[95:64], 32'h00001000);
      wait_drain(50);
      chk("t1_outstanding", tags_outstanding, 1);
      release_tag(0);
      chk("t1_released", tags_outstanding, 0);

      // split across MRRS boundaries with a 4DW address
      push(64'h1_0000_01F0, 11'd4,   0, 1, 1'b0);
      push(64'h1_0000_0200, 11'd128, 1, 1, 1'b0);
      push(64'h1_0000_0400, 11'd68,  2, 1, 1'b1);
      req(1, 64'h1_0000_01F0, 10'd200);
      wait_drain(100);
      chk("t2_outstanding", tags_outstanding, 3);

      // round-robin with all channels requesting, tags returned immediately
      do_reset();
      auto_rel = 1'b1;
      grant_cnt = 0;
      push(64'h3000, 11'd1, 0, 0, 1'b1);
      push(64'h3040, 11'd1, 0, 1, 1'b1);
      push(64'h3080, 11'd1, 0, 2, 1'b1);
      push(64'h30C0, 11'd1, 0, 3, 1'b1);
      push(64'h3000, 11'd1, 0, 0, 1'b1);
      for (int c = 0; c < CH; c++) begin
         ch_req_addr[64*c +: 64] = 64'h3000 + 64'(c * 64);
         ch_req_len[10*c +: 10]  = 10'd1;
      end
      ch_req_valid = 4'b1111;
      for (int i = 0; i < 300 && grant_cnt < 5; i++) tick();
      ch_req_valid = '0;
      chk("rr_grants", grant_cnt, 5);
      wait_drain(50);
      auto_rel = 1'b0;
      chk("rr_outstanding", tags_outstanding, 0);

      // tag exhaustion with a 4-tag pool
      for (int i = 0; i < 4; i++) push(64'h4000 + 64'(i * 16), 11'd1, i, 2, 1'b1);
      for (int i = 0; i < 4; i++) req(2, 64'h4000 + 64'(i * 16), 10'd1);
      wait_drain(50);
      req(2, 64'h4040, 10'd1);
      for (int i = 0; i < 6; i++) tick();
      chk("ex_tvalid_low", tx_if.s_axis_tx_tvalid, 0);
      chk("ex_outstanding", tags_outstanding, 4);
      push(64'h4040, 11'd1, 2, 2, 1'b1);
      release_tag(2);
      chk("ex_rel_lat0", tx_if.s_axis_tx_tvalid, 0);
      tick();
      chk("ex_rel_lat1", tx_if.s_axis_tx_tvalid, 1);
      wait_drain(50);
      chk("ex_full_again", tags_outstanding, 4);
      release_tag(0);
      chk("ex_rel_once", tags_outstanding, 3);
      release_tag(0);
      chk("ex_rel_twice", tags_outstanding, 3);

      // backpressure, plus allocate and release in the same cycle
      do_reset();
      push(64'h5000, 11'd1, 0, 3, 1'b1);
      req(3, 64'h5000, 10'd1);
      wait_drain(50);
      tx_if.s_axis_tx_tready = 1'b0;
      push(64'h6000, 11'd8, 1, 3, 1'b1);
      req(3, 64'h6000, 10'd8);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_tvalid", tx_if.s_axis_tx_tvalid, 1);
         chk("bp_tdata", tx_if.s_axis_tx_tdata, exp_hdr(64'h6000, 11'd8, 2'd1));
         chk("bp_no_issue", issue_valid, 0);
         tick();
      end
      tx_if.s_axis_tx_tready = 1'b1;
      release_tag(0);
      chk("bp_issue", issue_valid, 1);
      chk("bp_alloc_rel", tags_outstanding, 1);
      wait_drain(50);

      // reset in the middle of a split request
      do_reset();
      push(64'h8000, 11'd128, 0, 0, 1'b0);
      req(0, 64'h8000, 10'd512);
      wait_drain(50);
      ch_req_valid[0] = 1'b1;
      #2 i_rst_n = 1'b0;
      #1;
      chk("mr_tvalid", tx_if.s_axis_tx_tvalid, 0);
      chk("mr_tdata", tx_if.s_axis_tx_tdata, 0);
      chk("mr_tkeep", tx_if.s_axis_tx_tkeep, 0);
      chk("mr_tlast", tx_if.s_axis_tx_tlast, 0);
      chk("mr_ready", ch_req_ready, 0);
      chk("mr_outstanding", tags_outstanding, 0);
      chk("mr_issue", issue_valid, 0);
      tick(); tick();
      for (int i = 0; i < 4; i++) push(64'h8000 + 64'(i * 512), 11'd128, i, 0, i == 3);
      i_rst_n = 1'b1;
      req(0, 64'h8000, 10'd512);
      wait_drain(200);
      chk("mr_outstanding_end", tags_outstanding, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
